// File: rtl/sipo_deserializer_if.sv
// ---------------------------------------------------------------------------
// sipo_deserializer_if
// Word-side valid/ready handshake of the serial-in, parallel-out receiver.
//   word_valid : producer -> consumer, word_data holds an undelivered word
//   word_ready : consumer -> producer, word_data is taken this cycle
//   word_data  : producer -> consumer, assembled WIDTH-bit word
// The producer (the deserializer) uses the master modport and the consumer
// uses the slave modport.
// ---------------------------------------------------------------------------
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
// Serial-in, parallel-out receiver. Collects one bit per clock with
// bit_valid=1 into a WIDTH-bit word and hands each finished word to a
// one-word holding buffer exposed through a valid/ready port. The serial
// side cannot be stalled, so a word that completes while the buffer is
// still occupied (and not being drained) is dropped and overrun is set.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   clear      : synchronous abort of the partial word, also clears overrun
//   bit_valid  : bit_in is sampled on this edge
//   bit_in     : serial data bit
//   word_bus   : master side of the word handshake (valid/ready/data)
//   bit_count  : number of bits held in the partial word, 0..WIDTH-1
//   overrun    : sticky, a completed word was dropped
//
// Parameters
//   WIDTH      : word width, 2..32
//   LSB_FIRST  : 1 = first received bit lands in bit 0,
//                0 = first received bit lands in bit WIDTH-1
// ---------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    sipo_deserializer_if.master        word_bus,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_r;
    buf_state_t       state_nxt_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] sr_nxt_s;
    logic [WIDTH-1:0] sr_shift_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic             ovr_r;
    logic             ovr_nxt_s;
    logic             complete_s;

    // Shift register value after taking in bit_in, in the configured bit order.
    always_comb begin
        sr_shift_s = sr_r;
        if (LSB_FIRST) begin
            sr_shift_s = {bit_in, sr_r[WIDTH-1:1]};
        end else begin
            sr_shift_s = {sr_r[WIDTH-2:0], bit_in};
        end
    end

    // Next-state logic: bit assembly, buffer FSM and sticky overrun.
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        ovr_nxt_s   = ovr_r;
        complete_s  = 1'b0;

        // clear wins over an incoming bit, so a completion cannot coincide with it.
        if (clear) begin
            sr_nxt_s  = {WIDTH{1'b0}};
            cnt_nxt_s = {CW{1'b0}};
            ovr_nxt_s = 1'b0;
        end else if (bit_valid) begin
            sr_nxt_s = sr_shift_s;
            if (cnt_r == LAST_CNT) begin
                cnt_nxt_s  = {CW{1'b0}};
                complete_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            sr_nxt_s = sr_r;
        end

        case (state_r)
            EMPTY: begin
                // word_ready is meaningless while nothing is held.
                if (complete_s) begin
                    state_nxt_s = FULL;
                    data_nxt_s  = sr_shift_s;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (complete_s) begin
                    // Old word leaves as the new one arrives, or the new one is lost.
                    if (word_bus.word_ready) begin
                        data_nxt_s = sr_shift_s;
                    end else begin
                        ovr_nxt_s = 1'b1;
                    end
                end else if (word_bus.word_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
            sr_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            data_r  <= data_nxt_s;
            ovr_r   <= ovr_nxt_s;
        end
    end

    assign word_bus.word_valid = (state_r == FULL);
    assign word_bus.word_data  = data_r;
    assign bit_count           = cnt_r;
    assign overrun             = ovr_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deserializer
// Two receivers (LSB-first and MSB-first, WIDTH=4) share one serial stream
// and one ready line. Directed scenarios compare against literal words;
// the random scenario compares against a reference model that places each
// bit by its position in the word.
// ---------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int W = 4;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       bit_valid;
    logic       bit_in;
    logic       rdy;
    logic [2:0] l_cnt;
    logic [2:0] m_cnt_o;
    logic       l_ovr;
    logic       m_ovr_o;

    int n_checks;
    int n_pass;

    // reference model state
    int         m_cnt;
    logic [W-1:0] m_acc_l;
    logic [W-1:0] m_acc_m;
    logic [W-1:0] m_data_l;
    logic [W-1:0] m_data_m;
    logic       m_valid;
    logic       m_ovr;

    sipo_deserializer_if #(.WIDTH(W)) l_bus ();
    sipo_deserializer_if #(.WIDTH(W)) m_bus ();

    assign l_bus.word_ready = rdy;
    assign m_bus.word_ready = rdy;

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .word_bus  (l_bus.master),
        .bit_count (l_cnt),
        .overrun   (l_ovr)
    );

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .word_bus  (m_bus.master),
        .bit_count (m_cnt_o),
        .overrun   (m_ovr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt    = 0;
        m_acc_l  = '0;
        m_acc_m  = '0;
        m_data_l = '0;
        m_data_m = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic bv, input logic bi, input logic r);
        logic         done;
        logic [W-1:0] wl;
        logic [W-1:0] wm;
        done = 1'b0;
        wl   = '0;
        wm   = '0;
        if (c) begin
            m_cnt   = 0;
            m_acc_l = '0;
            m_acc_m = '0;
            m_ovr   = 1'b0;
        end else if (bv) begin
            if (bi) begin
                m_acc_l[m_cnt]       = 1'b1;
                m_acc_m[W - 1 - m_cnt] = 1'b1;
            end
            if (m_cnt == W - 1) begin
                done    = 1'b1;
                wl      = m_acc_l;
                wm      = m_acc_m;
                m_cnt   = 0;
                m_acc_l = '0;
                m_acc_m = '0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_valid  = 1'b1;
                m_data_l = wl;
                m_data_m = wm;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic c, input logic bv, input logic bi, input logic r);
        clear     = c;
        bit_valid = bv;
        bit_in    = bi;
        rdy       = r;
        @(posedge clk);
        model_edge(c, bv, bi, r);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (l_bus.word_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", l_bus.word_valid); else n_pass++;
        n_checks++; if (l_bus.word_data !== 4'h0) $display("FAIL reset_data got %h want 0", l_bus.word_data); else n_pass++;
        n_checks++; if (l_cnt !== 3'd0) $display("FAIL reset_count got %0d want 0", l_cnt); else n_pass++;
        n_checks++; if (l_ovr !== 1'b0) $display("FAIL reset_overrun got %b want 0", l_ovr); else n_pass++;
    endtask

    task automatic test_single_word();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (l_cnt !== 3'd3) $display("FAIL word_count3 got %0d want 3", l_cnt); else n_pass++;
        n_checks++; if (l_bus.word_valid !== 1'b0) $display("FAIL word_early_valid got %b want 0", l_bus.word_valid); else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (l_bus.word_valid !== 1'b1) $display("FAIL word_valid got %b want 1", l_bus.word_valid); else n_pass++;
        n_checks++; if (l_bus.word_data !== 4'hD) $display("FAIL lsb_word got %h want d", l_bus.word_data); else n_pass++;
        n_checks++; if (m_bus.word_data !== 4'hB) $display("FAIL msb_word got %h want b", m_bus.word_data); else n_pass++;
        n_checks++; if (l_cnt !== 3'd0) $display("FAIL word_count_wrap got %0d want 0", l_cnt); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (l_bus.word_valid !== 1'b0) $display("FAIL word_one_cycle got %b want 0", l_bus.word_valid); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] stream;
        stream = 8'b0010_0001;  // sent LSB of this vector first: 1,0,0,0,0,1,0,0
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, stream[i], 1'b0);
        n_checks++; if (l_bus.word_data !== 4'h1) $display("FAIL ovr_lsb_data got %h want 1", l_bus.word_data); else n_pass++;
        n_checks++; if (m_bus.word_data !== 4'h8) $display("FAIL ovr_msb_data got %h want 8", m_bus.word_data); else n_pass++;
        n_checks++; if (l_ovr !== 1'b1) $display("FAIL ovr_set got %b want 1", l_ovr); else n_pass++;
        n_checks++; if (l_bus.word_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", l_bus.word_valid); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (l_bus.word_valid !== 1'b0) $display("FAIL ovr_drain got %b want 0", l_bus.word_valid); else n_pass++;
        n_checks++; if (m_ovr_o !== 1'b1) $display("FAIL ovr_sticky got %b want 1", m_ovr_o); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (l_ovr !== 1'b0) $display("FAIL ovr_clear got %b want 0", l_ovr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (l_bus.word_data !== 4'h1) $display("FAIL b2b_first got %h want 1", l_bus.word_data); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (l_bus.word_data !== 4'h1) $display("FAIL b2b_stable got %h want 1", l_bus.word_data); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (l_bus.word_data !== 4'h6) $display("FAIL b2b_lsb got %h want 6", l_bus.word_data); else n_pass++;
        n_checks++; if (m_bus.word_data !== 4'h6) $display("FAIL b2b_msb got %h want 6", m_bus.word_data); else n_pass++;
        n_checks++; if (l_bus.word_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", l_bus.word_valid); else n_pass++;
        n_checks++; if (l_ovr !== 1'b0) $display("FAIL b2b_overrun got %b want 0", l_ovr); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (l_cnt !== 3'd2) $display("FAIL clr_pre got %0d want 2", l_cnt); else n_pass++;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (l_cnt !== 3'd0) $display("FAIL clr_count got %0d want 0", l_cnt); else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (l_bus.word_data !== 4'hF) $display("FAIL clr_lsb got %h want f", l_bus.word_data); else n_pass++;
        n_checks++; if (m_bus.word_data !== 4'hF) $display("FAIL clr_msb got %h want f", m_bus.word_data); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (l_cnt !== 3'd2 || l_bus.word_valid !== 1'b1) $display("FAIL arst_pre got cnt=%0d valid=%b want cnt=2 valid=1", l_cnt, l_bus.word_valid); else n_pass++;
        bit_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        // Still before the next rising edge.
        n_checks++; if (l_bus.word_valid !== 1'b0 || l_bus.word_data !== 4'h0) $display("FAIL arst_word got valid=%b data=%h want 0/0", l_bus.word_valid, l_bus.word_data); else n_pass++;
        n_checks++; if (l_cnt !== 3'd0 || m_cnt_o !== 3'd0) $display("FAIL arst_count got %0d/%0d want 0", l_cnt, m_cnt_o); else n_pass++;
        n_checks++; if (m_bus.word_valid !== 1'b0 || m_bus.word_data !== 4'h0) $display("FAIL arst_msb got valid=%b data=%h want 0/0", m_bus.word_valid, m_bus.word_data); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (l_bus.word_data !== 4'hA) $display("FAIL arst_clean_lsb got %h want a", l_bus.word_data); else n_pass++;
        n_checks++; if (m_bus.word_data !== 4'h5) $display("FAIL arst_clean_msb got %h want 5", m_bus.word_data); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
            n_checks++;
            if (l_bus.word_valid !== m_valid || m_bus.word_valid !== m_valid ||
                (m_valid && (l_bus.word_data !== m_data_l || m_bus.word_data !== m_data_m)) ||
                l_cnt !== 3'(m_cnt) || m_cnt_o !== 3'(m_cnt) ||
                l_ovr !== m_ovr || m_ovr_o !== m_ovr) begin
                if (errs < 10) $display("FAIL rand_cycle%0d got v=%b d=%h/%h c=%0d o=%b want v=%b d=%h/%h c=%0d o=%b",
                    i, l_bus.word_valid, l_bus.word_data, m_bus.word_data, l_cnt, l_ovr,
                    m_valid, m_data_l, m_data_m, m_cnt, m_ovr);
                errs++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_word();
        test_overrun();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
